sd_dat_fifo: RTL and testbench
==============================

// Module: sd_dat_fifo
// PURPOSE
//  Single-clock 32-bit data FIFO feeding the DAT-line controller.
//  - Host/DMA side writes words with push.
//  - DAT side reads words with pop and serialises them to the SD card.
//  - First-word-fall-through: the head word is always presented on fromFifo_toPS.
//  - fifo_full/fifo_empty give the DAT stage its flow control and stall indications.
// PARAMETERS
//  DATA_WIDTH   32  word width, bits
//  DEPTH        16  entries; power of two, >=4
//  AF_LEVEL     12  almost_full asserts when count >= AF_LEVEL
//  AE_LEVEL      4  almost_empty asserts when count <= AE_LEVEL
// PORTS
//  clock          in   1              system clock, rising edge
//  reset          in   1              asynchronous, active-low
//  flush          in   1              synchronous clear of contents and sticky flags
//  push           in   1              write strobe, host side
//  data_in        in   DATA_WIDTH     word to write
//  pop            in   1              read strobe, DAT side
//  fromFifo_toPS  out  DATA_WIDTH     head word (FWFT); 0 when empty
//  fifo_full      out  1              count == DEPTH
//  fifo_empty     out  1              count == 0
//  almost_full    out  1              count >= AF_LEVEL
//  almost_empty   out  1              count <= AE_LEVEL
//  count          out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
//  overflow       out  1              sticky: push rejected while full
//  underflow      out  1              sticky: pop rejected while empty
// BEHAVIOUR
//  Reset (reset=0, async): wr_ptr=rd_ptr=0; count=0; fifo_empty=1; almost_empty=1;
//    fifo_full=0; almost_full=0; overflow=underflow=0; fromFifo_toPS=0.
//    Storage array is not reset.
//  Pointers: ADDR_W=$clog2(DEPTH) bits, wrap DEPTH-1 -> 0.
//    count is a separate ADDR_W+1 register; full and empty derive from count only.
//  All status outputs are registered and update on the same edge as count.
//    They are never combinational from push/pop.
//  Per rising edge, evaluated in priority order:
//   1. flush=1: pointers=0, count=0, overflow=underflow=0; push/pop that cycle ignored.
//   2. push & !full: mem[wr_ptr]<=data_in; wr_ptr++.
//      push & full & !pop: write dropped; overflow<=1.
//   3. pop & !empty: rd_ptr++.
//      pop & empty: nothing read; underflow<=1.
//   4. count += accepted_push - accepted_pop.
//  Simultaneous push+pop:
//   - full: both accepted; count stays DEPTH; no overflow.
//   - empty: push accepted; pop rejected with underflow; count becomes 1.
//   - otherwise: both accepted; count unchanged.
//  Latency: word pushed at edge N appears on fromFifo_toPS and fifo_empty=0 after edge N.
//    pop at edge N shows the next word after edge N; zero-bubble back-to-back pops.
//  fromFifo_toPS = fifo_empty ? 0 : mem[rd_ptr], an async read of a registered array.
//  Sticky flags clear only on reset or flush.
//  Reset asserted mid-transfer discards all contents immediately, with no handshake.
// STRUCTURE
//  sd_host_pkg:
//   - SD_WORD_W=32 and typedef logic [SD_WORD_W-1:0] sd_word_t.
//   - Default DEPTH, AF_LEVEL and AE_LEVEL constants, shared with the DAT controller.
//  Sub-module sd_fifo_ram: DEPTH x DATA_WIDTH register array.
//   - Sync write: we, waddr, wdata.
//   - Async read: raddr -> rdata.
//  Pointer, count and flag logic live in sd_dat_fifo.
// TESTING
//  1. Reset, then push 0xC0000003 -> after 1 edge: fromFifo_toPS=0xC0000003, count=1, fifo_empty=0.
//  2. Push 16 words 0..15 -> fifo_full=1, almost_full=1 from count 12.
//     17th push -> overflow=1, count=16, head=0.
//  3. From full, push 0xE000 with pop together -> count=16, overflow=0.
//     Pops then yield 1..15, then 0xE000 in order.
//  4. Pop on empty -> underflow=1, count=0.
//     Push+pop together on empty -> count=1, head=pushed word.
//  5. Wrap: 40 interleaved push/pop cycles at count ~8 -> data order preserved across pointer wrap.
//     count never <0 or >16.
//  6. Flush with push=1 at count=5 -> count=0, empty=1, sticky flags 0.
//     Async reset mid-burst -> all outputs at reset values before next edge.

Source files
------------

// File: rtl/sd_host_pkg.sv
// Shared SD host constants and types: word width and default DAT FIFO sizing,
// common to the DAT FIFO and the DAT-line controller.
package sd_host_pkg;

    localparam int SD_WORD_W = 32;
    typedef logic [SD_WORD_W-1:0] sd_word_t;

    localparam int SD_FIFO_DEPTH    = 16;
    localparam int SD_FIFO_AF_LEVEL = 12;
    localparam int SD_FIFO_AE_LEVEL = 4;

endpackage

// File: rtl/sd_fifo_ram.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module sd_fifo_ram
    import sd_host_pkg::*;
#(
    parameter int DATA_WIDTH = SD_WORD_W,
    parameter int DEPTH      = SD_FIFO_DEPTH,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sd_dat_fifo.sv
// First-word-fall-through data FIFO between the host/DMA side and the DAT-line
// serialiser, with registered occupancy flags and sticky overflow/underflow.
module sd_dat_fifo
    import sd_host_pkg::*;
#(
    parameter int DATA_WIDTH = SD_WORD_W,
    parameter int DEPTH      = SD_FIFO_DEPTH,
    parameter int AF_LEVEL   = SD_FIFO_AF_LEVEL,
    parameter int AE_LEVEL   = SD_FIFO_AE_LEVEL,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int CNT_W     = ADDR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] fromFifo_toPS,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_AF    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]  CNT_AE    = CNT_W'(AE_LEVEL);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      count_nxt;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  push_ok;
    logic                  pop_ok;

    // When full, a simultaneous pop frees the head slot on the same edge, so
    // the write into that slot lands behind the advancing read pointer.
    assign push_ok = push & (~fifo_full | pop);
    assign pop_ok  = pop & ~fifo_empty;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fifo_full    <= 1'b0;
            fifo_empty   <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fifo_full    <= 1'b0;
            fifo_empty   <= 1'b1;
            almost_full  <= (CNT_AF == '0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop && fifo_empty) begin
                underflow <= 1'b1;
            end
            // Flags are registered from the next count so they move with count.
            count        <= count_nxt;
            fifo_full    <= (count_nxt == CNT_DEPTH);
            fifo_empty   <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CNT_AF);
            almost_empty <= (count_nxt <= CNT_AE);
        end
    end

    sd_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (push_ok & ~flush & reset),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign fromFifo_toPS = fifo_empty ? '0 : ram_rdata;

endmodule

// File: tb/tb_sd_dat_fifo.sv
// Randomised and directed bench for sd_dat_fifo against a queue-based reference model.
module tb_sd_dat_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        push;
    logic        pop;
    logic [31:0] data_in;
    logic [31:0] fromFifo_toPS;
    logic        fifo_full;
    logic        fifo_empty;
    logic        almost_full;
    logic        almost_empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q [$];
    bit          m_ov;
    bit          m_un;

    always #5 clock = ~clock;

    sd_dat_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .push          (push),
        .data_in       (data_in),
        .pop           (pop),
        .fromFifo_toPS (fromFifo_toPS),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ph);
        int n;
        logic [31:0] exp_head;
        n = q.size();
        exp_head = (n == 0) ? 32'h0 : q[0];
        chk({ph, ":head"},   fromFifo_toPS,      exp_head);
        chk({ph, ":count"},  32'(count),         32'(n));
        chk({ph, ":full"},   32'(fifo_full),     32'(n == DEPTH));
        chk({ph, ":empty"},  32'(fifo_empty),    32'(n == 0));
        chk({ph, ":afull"},  32'(almost_full),   32'(n >= AF));
        chk({ph, ":aempty"}, 32'(almost_empty),  32'(n <= AE));
        chk({ph, ":ovf"},    32'(overflow),      32'(m_ov));
        chk({ph, ":unf"},    32'(underflow),     32'(m_un));
    endtask

    // One clock edge: drive, update reference model at the edge, check on the falling edge.
    task automatic step(input string ph, input bit pu, input bit po, input bit fl,
                        input logic [31:0] d);
        int  n;
        bit  acc_pu;
        push = pu; pop = po; flush = fl; data_in = d;
        @(posedge clock);
        if (fl) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            n = q.size();
            acc_pu = pu && (n < DEPTH || po);
            if (pu && n == DEPTH && !po) m_ov = 1'b1;
            if (po && n == 0) m_un = 1'b1;
            if (po && n > 0) void'(q.pop_front());
            if (acc_pu) q.push_back(d);
        end
        @(negedge clock);
        push = 1'b0; pop = 1'b0; flush = 1'b0;
        check_all(ph);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
        m_ov = 1'b0; m_un = 1'b0;
        repeat (2) @(negedge clock);
        check_all("reset");
        reset = 1'b1;

        step("t1_push", 1, 0, 0, 32'hC000_0003);

        step("t2_flush", 0, 0, 1, 32'h0);
        for (int i = 0; i < 16; i++) step("t2_fill", 1, 0, 0, 32'(i));
        step("t2_ovf", 1, 0, 0, 32'hDEAD_BEEF);

        step("t3_flush", 0, 0, 1, 32'h0);
        for (int i = 0; i < 16; i++) step("t3_fill", 1, 0, 0, 32'(i));
        step("t3_pushpop_full", 1, 1, 0, 32'h0000_E000);
        for (int i = 0; i < 16; i++) step("t3_drain", 0, 1, 0, 32'h0);

        step("t4_pop_empty", 0, 1, 0, 32'h0);
        step("t4_pushpop_empty", 1, 1, 0, $urandom);

        step("t5_flush", 0, 0, 1, 32'h0);
        for (int i = 0; i < 8; i++) step("t5_fill", 1, 0, 0, $urandom);
        for (int i = 0; i < 40; i++)
            step("t5_wrap", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, $urandom);
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0), $urandom);

        step("t6_flush0", 0, 0, 1, 32'h0);
        for (int i = 0; i < 5; i++) step("t6_fill", 1, 0, 0, $urandom);
        step("t6_flush_push", 1, 0, 1, 32'h1234_5678);

        for (int i = 0; i < 17; i++) step("t6_burst", 1, 0, 0, $urandom);
        push = 1'b1; data_in = $urandom;
        @(posedge clock);
        #3;
        reset = 1'b0;
        q.delete(); m_ov = 1'b0; m_un = 1'b0;
        #1;
        check_all("t6_async_rst");
        push = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step("t6_after_rst", 1, 0, 0, 32'hA5A5_0001);
        step("t6_after_rst2", 0, 1, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
